// File: rtl/pmc_dc_conf_shifter.sv
// DC configuration register with a serial shifter that streams the register
// MSB first to the pixel matrix after every accepted write.
module pmc_dc_conf_shifter #(
    parameter logic [31:0] DC_RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hit,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        dc_sclk,
    output logic        dc_sdata,
    output logic        dc_load,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t      state;
    logic [31:0] conf;
    logic [31:0] conf_next;
    logic [31:0] shift_reg;
    logic [31:0] reload_val;
    logic [4:0]  bit_cnt;
    logic        phase;
    logic        pending;
    logic        accept;

    always_comb begin
        accept    = hit & we & (|be);
        conf_next = conf;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) conf_next[8*i +: 8] = wdata[8*i +: 8];
        end
        // A write landing on the LOAD exit edge is folded into the reload.
        reload_val = accept ? conf_next : conf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf  <= DC_RESET_VALUE;
            rdata <= '0;
        end else begin
            if (accept) conf <= conf_next;
            if (hit && !we) rdata <= conf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            pending   <= 1'b0;
            dc_sclk   <= 1'b0;
            dc_sdata  <= 1'b0;
            dc_load   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dc_sclk <= 1'b0;
                    dc_load <= 1'b0;
                    if (accept) begin
                        state     <= SHIFT;
                        shift_reg <= conf_next;
                        bit_cnt   <= 5'd31;
                        phase     <= 1'b0;
                        dc_sdata  <= conf_next[31];
                        busy      <= 1'b1;
                    end else begin
                        dc_sdata <= 1'b0;
                        busy     <= 1'b0;
                    end
                end

                SHIFT: begin
                    busy <= 1'b1;
                    if (accept) pending <= 1'b1;
                    if (!phase) begin
                        phase   <= 1'b1;
                        dc_sclk <= 1'b1;
                    end else begin
                        phase     <= 1'b0;
                        dc_sclk   <= 1'b0;
                        shift_reg <= shift_reg << 1;
                        if (bit_cnt == 5'd0) begin
                            state    <= LOAD;
                            dc_load  <= 1'b1;
                            dc_sdata <= 1'b0;
                        end else begin
                            bit_cnt  <= bit_cnt - 5'd1;
                            dc_sdata <= shift_reg[30];
                        end
                    end
                end

                LOAD: begin
                    dc_load <= 1'b0;
                    dc_sclk <= 1'b0;
                    if (pending || accept) begin
                        state     <= SHIFT;
                        shift_reg <= reload_val;
                        bit_cnt   <= 5'd31;
                        phase     <= 1'b0;
                        pending   <= 1'b0;
                        dc_sdata  <= reload_val[31];
                        busy      <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        dc_sdata <= 1'b0;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    dc_sclk  <= 1'b0;
                    dc_sdata <= 1'b0;
                    dc_load  <= 1'b0;
                    busy     <= pending;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmc_dc_conf_shifter.sv
// Randomized and directed bench for pmc_dc_conf_shifter against a
// frame-timing reference model (65-cycle frames, coalesced pending flag).
module tb_pmc_dc_conf_shifter;

    localparam logic [31:0] RST_VAL = 32'h5A5A_0FF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hit;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        dc_sclk;
    logic        dc_sdata;
    logic        dc_load;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Reference model: m_rem counts cycles left in the current frame
    // (65 = first shift cycle, 1 = load cycle, 0 = idle).
    logic [31:0] m_conf;
    logic [31:0] m_rdata;
    logic [31:0] m_frame;
    int          m_rem;
    bit          m_pend;

    pmc_dc_conf_shifter #(.DC_RESET_VALUE(RST_VAL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hit      (hit),
        .we       (we),
        .be       (be),
        .wdata    (wdata),
        .rdata    (rdata),
        .dc_sclk  (dc_sclk),
        .dc_sdata (dc_sdata),
        .dc_load  (dc_load),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] b,
                                          input logic [31:0] d);
        logic [31:0] res = old;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) res = (res & ~(32'hFF << (8 * k))) | (d & (32'hFF << (8 * k)));
        end
        return res;
    endfunction

    // Expected {busy, dc_load, dc_sclk, dc_sdata} for the current cycle.
    function automatic logic [3:0] exp_out();
        logic e_busy = (m_rem > 0) || m_pend;
        logic e_load = (m_rem == 1);
        logic e_sclk = 1'b0;
        logic e_sdata = 1'b0;
        int p;
        if (m_rem >= 2) begin
            p = 65 - m_rem;
            e_sclk = (p % 2) == 1;
            e_sdata = m_frame[31 - p / 2];
        end
        return {e_busy, e_load, e_sclk, e_sdata};
    endfunction

    function automatic void model_reset();
        m_conf  = RST_VAL;
        m_rdata = '0;
        m_frame = '0;
        m_rem   = 0;
        m_pend  = 0;
    endfunction

    task automatic step(input logic h, input logic w, input logic [3:0] b, input logic [31:0] d);
        bit          acc;
        logic [31:0] nc;
        hit = h; we = w; be = b; wdata = d;
        @(posedge clk);
        acc = h && w && (b != 4'h0);
        nc  = acc ? merge(m_conf, b, d) : m_conf;
        if (h && !w) m_rdata = m_conf;
        if (m_rem == 0) begin
            if (acc) begin
                m_frame = nc;
                m_rem   = 65;
            end
        end else if (m_rem == 1) begin
            if (m_pend || acc) begin
                m_frame = nc;
                m_rem   = 65;
                m_pend  = 0;
            end else begin
                m_rem = 0;
            end
        end else begin
            m_rem--;
            if (acc) m_pend = 1;
        end
        m_conf = nc;
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (m_rem != 0 || m_pend); i++) step(0, 0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hit = 0; we = 0; be = 0; wdata = 0;
        model_reset();
        #3;
        checks++;
        if ({busy, dc_load, dc_sclk, dc_sdata} !== 4'b0000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b rdata=%h exp=0000 rdata=0",
                     {busy, dc_load, dc_sclk, dc_sdata}, rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1, 0, 4'h0, 32'h0);
        checks++;
        if (rdata !== RST_VAL) begin
            errors++;
            $display("FAIL reset_read got=%h exp=%h", rdata, RST_VAL);
        end
    endtask

    task automatic test_serial_frame();
        logic [31:0] bits = '0;
        int          rises = 0;
        logic        prev = 1'b0;
        step(1, 1, 4'hF, 32'hA5C3_0F81);
        for (int c = 1; c <= 66; c++) begin
            if (c > 1) step(0, 0, 4'h0, 32'h0);
            checks++;
            if ({busy, dc_load, dc_sclk, dc_sdata} !== exp_out()) begin
                errors++;
                $display("FAIL frame_outputs cyc=%0d got=%b exp=%b", c,
                         {busy, dc_load, dc_sclk, dc_sdata}, exp_out());
            end
            if (dc_sclk && !prev) begin
                bits = {bits[30:0], dc_sdata};
                rises++;
            end
            prev = dc_sclk;
            if (c == 65) begin
                checks++;
                if (dc_load !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_load_cycle got=%b exp=1", dc_load);
                end
            end
            if (c == 66) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_busy_fall got=%b exp=0", busy);
                end
            end
        end
        checks++;
        if (bits !== 32'hA5C3_0F81 || rises != 32) begin
            errors++;
            $display("FAIL frame_bits got=%h rises=%0d exp=a5c30f81 rises=32", bits, rises);
        end
    endtask

    task automatic test_byte_merge();
        step(1, 1, 4'hF, 32'h1122_3344);
        wait_idle();
        step(1, 1, 4'b0101, 32'hFFFF_FFFF);
        step(1, 0, 4'h0, 32'h0);
        checks++;
        if (rdata !== 32'h11FF_33FF) begin
            errors++;
            $display("FAIL byte_merge got=%h exp=11ff33ff", rdata);
        end
        wait_idle();
    endtask

    task automatic test_coalesce();
        logic [31:0] bits = '0;
        logic [31:0] frames[$];
        logic        prev = 1'b0;
        for (int c = 1; c <= 131; c++) begin
            if (c == 1)       step(1, 1, 4'hF, 32'h0000_0001);
            else if (c == 44) step(1, 1, 4'hF, 32'h8000_0000);
            else if (c == 54) step(1, 1, 4'hF, 32'hC000_0000);
            else              step(0, 0, 4'h0, 32'h0);
            checks++;
            if ({busy, dc_load, dc_sclk, dc_sdata} !== exp_out()) begin
                errors++;
                $display("FAIL coalesce_outputs cyc=%0d got=%b exp=%b", c,
                         {busy, dc_load, dc_sclk, dc_sdata}, exp_out());
            end
            checks++;
            if (busy !== (c <= 130)) begin
                errors++;
                $display("FAIL coalesce_busy cyc=%0d got=%b exp=%b", c, busy, c <= 130);
            end
            if (dc_sclk && !prev) bits = {bits[30:0], dc_sdata};
            prev = dc_sclk;
            if (dc_load) frames.push_back(bits);
        end
        checks++;
        if (frames.size() != 2) begin
            errors++;
            $display("FAIL coalesce_frame_count got=%0d exp=2", frames.size());
        end else if (frames[0] !== 32'h0000_0001 || frames[1] !== 32'hC000_0000) begin
            errors++;
            $display("FAIL coalesce_frames got=%h,%h exp=00000001,c0000000", frames[0], frames[1]);
        end
    endtask

    task automatic test_ignored();
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) step(1, 1, 4'h0, $urandom);
            else            step(1, 0, 4'h0, 32'h0);
            checks++;
            if (dc_sclk !== 1'b0 || busy !== 1'b0 || rdata !== m_rdata) begin
                errors++;
                $display("FAIL ignored cyc=%0d sclk=%b busy=%b rdata=%h exp sclk=0 busy=0 rdata=%h",
                         c, dc_sclk, busy, rdata, m_rdata);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            int r = $urandom_range(99);
            if (r < 3)       step(1, 1, 4'($urandom), $urandom);
            else if (r < 20) step(1, 0, 4'($urandom), $urandom);
            else             step(0, 1'($urandom), 4'($urandom), $urandom);
            checks++;
            if ({busy, dc_load, dc_sclk, dc_sdata} !== exp_out() || rdata !== m_rdata) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b/%h exp=%b/%h", c,
                         {busy, dc_load, dc_sclk, dc_sdata}, rdata, exp_out(), m_rdata);
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_midshift();
        step(1, 1, 4'hF, $urandom | 32'h0001_0000);
        for (int c = 0; c < 22; c++) step(0, 0, 4'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, dc_load, dc_sclk, dc_sdata} !== 4'b0000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL midshift_async got=%b rdata=%h exp=0000 rdata=0",
                     {busy, dc_load, dc_sclk, dc_sdata}, rdata);
        end
        model_reset();
        hit = 0; we = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, dc_load, dc_sclk, dc_sdata} !== 4'b0000) begin
                errors++;
                $display("FAIL midshift_held cyc=%0d got=%b exp=0000", c,
                         {busy, dc_load, dc_sclk, dc_sdata});
            end
        end
        rst_n = 1'b1;
        step(1, 0, 4'h0, 32'h0);
        checks++;
        if (rdata !== RST_VAL) begin
            errors++;
            $display("FAIL midshift_read got=%h exp=%h", rdata, RST_VAL);
        end
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 4'h0, 32'h0);
            checks++;
            if ({busy, dc_load, dc_sclk, dc_sdata} !== 4'b0000) begin
                errors++;
                $display("FAIL midshift_idle cyc=%0d got=%b exp=0000", c,
                         {busy, dc_load, dc_sclk, dc_sdata});
            end
        end
    endtask

    initial begin
        test_reset();
        test_serial_frame();
        test_byte_merge();
        test_coalesce();
        test_ignored();
        test_random();
        test_reset_midshift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmc_dc_conf_shifter.md
PMC_DC_CONF_SHIFTER -- requirements
Module: pmc_dc_conf_shifter

Interface
REQ-001 Parameter: DC_RESET_VALUE, default 32'h0000_0000, reset value of the configuration register.
REQ-002 Signal: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Signal: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Signal: hit  input  1  grant from the offset decoder: the current bus request targets DC register 0.
REQ-005 Signal: we  input  1  write enable of the current request; 0 = read.
REQ-006 Signal: be  input  4  byte enables; be[i] qualifies wdata[8i+7:8i].
REQ-007 Signal: wdata  input  32  write data.
REQ-008 Signal: rdata  output  32  read data, valid in the cycle the decoder asserts rvalid.
REQ-009 Signal: dc_sclk  output  1  serial configuration clock to the pixel matrix.
REQ-010 Signal: dc_sdata  output  1  serial configuration data, MSB first.
REQ-011 Signal: dc_load  output  1  one-cycle latch strobe after the last bit.
REQ-012 Signal: busy  output  1  shift in progress or pending.

Function
REQ-013 The block SHALL hold one 32-bit configuration register (conf).
REQ-014 Write accept: at a rising edge with hit=1, we=1 and be!=0, each byte of conf with be[i]=1 SHALL take wdata byte i; other bytes SHALL keep their value.
REQ-015 A write with be=4'b0000 SHALL be ignored completely: conf unchanged, no shift started, pending unchanged.
REQ-016 Read: at a rising edge with hit=1 and we=0, rdata SHALL load the current conf; otherwise rdata SHALL hold its value (1-cycle latency, aligned with decoder rvalid).
REQ-017 FSM states SHALL be IDLE, SHIFT and LOAD.
REQ-018 IDLE -> SHIFT on an accepted write; the shift register SHALL load the post-merge conf value on that same edge and the bit counter SHALL be set to 31.
REQ-019 In SHIFT, each bit SHALL take 2 cycles: phase 0 with dc_sclk=0 and dc_sdata=shift[31], then phase 1 with dc_sclk=1 and dc_sdata unchanged.
REQ-020 At the end of phase 1, the shift register SHALL shift left by 1 and the counter SHALL decrement; after the phase 1 of bit 0 the FSM SHALL go to LOAD (64 SHIFT cycles total).
REQ-021 LOAD SHALL last exactly 1 cycle with dc_load=1, dc_sclk=0 and dc_sdata=0.
REQ-022 From LOAD, the FSM SHALL go to SHIFT if pending=1, reloading from the current conf and clearing pending; otherwise it SHALL go to IDLE.
REQ-023 An accepted write while in SHIFT or LOAD SHALL update conf immediately (REQ-014), set pending=1 and not disturb the shift in progress.
REQ-024 Multiple writes while busy SHALL coalesce into one pending flag; the next shift SHALL carry the latest conf.
REQ-025 busy SHALL be 1 whenever state!=IDLE or pending=1.
REQ-026 In IDLE, dc_sclk, dc_sdata and dc_load SHALL be 0.
REQ-027 Reads SHALL never start a shift, and SHALL return conf including any write made during an active shift.
REQ-028 All outputs SHALL be driven directly from flops (no combinational path from inputs).

Reset
REQ-029 While rst_n=0: conf=DC_RESET_VALUE, rdata=0, state=IDLE, pending=0, counter=0, and dc_sclk, dc_sdata, dc_load and busy all 0.
REQ-030 Reset asserted mid-shift SHALL abort immediately with no dc_load pulse; after release the block SHALL remain IDLE until the next write.

Verification
REQ-031 Write 32'hA5C3_0F81 with be=4'hF from IDLE -> 64 SHIFT cycles; dc_sdata sampled on each dc_sclk rise = 1,0,1,0,0,1,0,1,... (MSB first); dc_load=1 on cycle 65; busy falls on cycle 66.
REQ-032 conf=32'h1122_3344, write 32'hFFFF_FFFF with be=4'b0101, then read -> rdata=32'h11FF_33FF one cycle after the read hit.
REQ-033 During a shift of 32'h0000_0001, write 32'h8000_0000 at bit 10 and 32'hC000_0000 at bit 5 -> the first frame completes unchanged, exactly one further frame follows immediately after LOAD carrying 32'hC000_0000, and busy stays 1 throughout.
REQ-034 Write with be=0 and a read with hit=1 in IDLE -> no dc_sclk activity and busy stays 0.
REQ-035 Assert rst_n=0 at bit 20 of a shift -> all outputs 0 asynchronously, no dc_load; a read after release returns DC_RESET_VALUE.
